etapa_mem: RTL

ETAPA_MEM -- requirements
Module: etapa_mem

---
 rtl/etapa_mem.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/etapa_mem.sv
// MEM pipeline stage: issues one aligned load/store per instruction to a handshaked
// memory, stalls upstream while waiting, and loads the MEM/WB register.
module etapa_mem #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [63:0] ALU_Result_in,
  input  logic [63:0] wr_data_in,
  input  logic [4:0]  dir_rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic [63:0] ALU_Result_out,
  output logic [63:0] rd_data_out,
  output logic [4:0]  dir_rd_out,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        lat_mtr_q, lat_mtr_d;
  logic        lat_rw_q, lat_rw_d;
  logic [4:0]  lat_rd_q, lat_rd_d;
  logic [63:0] lat_data_q, lat_data_d;
  logic        failed_q, failed_d;
  logic        wb_mtr_q, wb_mtr_d;
  logic        wb_rw_q, wb_rw_d;
  logic [63:0] wb_alu_q, wb_alu_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        bus_err_q, bus_err_d;
  logic        mis_err_q, mis_err_d;

  logic mem_op, aligned;
  assign mem_op  = MemWrite_in | MemtoReg_in;
  assign aligned = (ALU_Result_in[2:0] == 3'b000);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_mtr_d   = lat_mtr_q;
    lat_rw_d    = lat_rw_q;
    lat_rd_d    = lat_rd_q;
    lat_data_d  = lat_data_q;
    failed_d    = failed_q;
    wb_mtr_d    = wb_mtr_q;
    wb_rw_d     = wb_rw_q;
    wb_alu_d    = wb_alu_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    bus_err_d   = bus_err_q;
    mis_err_d   = mis_err_q;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          wb_mtr_d = MemtoReg_in;
          wb_rw_d  = RegWrite_in;
          wb_alu_d = ALU_Result_in;
          wb_rd_d  = dir_rd_in;
        end else begin
          wb_mtr_d = 1'b0;
          wb_rw_d  = 1'b0;
          if (aligned) begin
            // Gated by reset so a held memory op cannot stall the pipe during reset.
            stall       = rst;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite_in;
            mem_addr_d  = ALU_Result_in;
            mem_wdata_d = wr_data_in;
            lat_mtr_d   = MemtoReg_in & ~MemWrite_in;
            lat_rw_d    = RegWrite_in;
            lat_rd_d    = dir_rd_in;
            failed_d    = 1'b0;
            cnt_d       = 8'd0;
            state_d     = S_WAIT;
          end else begin
            mis_err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall    = 1'b1;
        wb_mtr_d = 1'b0;
        wb_rw_d  = 1'b0;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) lat_data_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) begin
            bus_err_d = 1'b1;
            failed_d  = 1'b1;
            mem_req_d = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        wb_rw_d  = lat_rw_q & ~failed_q;
        wb_mtr_d = lat_mtr_q & ~failed_q;
        wb_alu_d = mem_addr_q;
        wb_rd_d  = lat_rd_q;
        if (!mem_we_q && !failed_q) wb_data_d = lat_data_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      lat_mtr_q   <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_rd_q    <= 5'd0;
      lat_data_q  <= 64'd0;
      failed_q    <= 1'b0;
      wb_mtr_q    <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_alu_q    <= 64'd0;
      wb_data_q   <= 64'd0;
      wb_rd_q     <= 5'd0;
      bus_err_q   <= 1'b0;
      mis_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_mtr_q   <= lat_mtr_d;
      lat_rw_q    <= lat_rw_d;
      lat_rd_q    <= lat_rd_d;
      lat_data_q  <= lat_data_d;
      failed_q    <= failed_d;
      wb_mtr_q    <= wb_mtr_d;
      wb_rw_q     <= wb_rw_d;
      wb_alu_q    <= wb_alu_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      bus_err_q   <= bus_err_d;
      mis_err_q   <= mis_err_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign MemtoReg_out   = wb_mtr_q;
  assign RegWrite_out   = wb_rw_q;
  assign ALU_Result_out = wb_alu_q;
  assign rd_data_out    = wb_data_q;
  assign dir_rd_out     = wb_rd_q;
  assign bus_err        = bus_err_q;
  assign misalign_err   = mis_err_q;

endmodule
